// File: rtl/serial_add_seq_pkg.sv
// Shared constants for the bit-serial adder: state encoding and default sizing.
package serial_add_seq_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_seq_fa_cell.sv
// One-bit combinational full adder used as the serial adder's arithmetic cell.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder: one full-adder cell fed LSB first, start/busy/done handshake.
// Defining SERIAL_ADD_OVF_EN adds a two's-complement overflow output held with sum.
module serial_add_seq
  import serial_add_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               fa_s, fa_co;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  fa_cell u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .c  (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        carry_d = fa_co;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        // Final bit: publish the whole result at once so partial sums never leak out.
        if (cnt_q == LAST_CNT) begin
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ fa_co;
`endif
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed, table-driven bench for serial_add_seq (WIDTH=8), with hand sequences for overlap and reset abort.
module tb_serial_add_seq;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf;
`endif

  int tests  = 0;
  int failed = 0;
  logic [7:0] prev_sum = 8'h00;
  vec_t vecs[9];

  serial_add_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Presents operands with start for one edge (E0); returns just after E0.
  task automatic launch(input vec_t v);
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done, then checks latency, result, busy span and done width.
  // inj_at != 0 re-requests start with different operands at edge E0+inj_at.
  task automatic finish_op(input vec_t v, input int inj_at);
    int lat;
    int bc;
    lat = 0;
    bc  = busy ? 1 : 0;
    while (!done && lat < 30) begin
      if (inj_at != 0 && lat + 1 == inj_at) begin
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      if (busy) bc++;
      if (!done && lat == 4) chk("sum_hidden_midflight", sum, prev_sum);
    end
    chk("done_latency", lat, 8);
    chk("sum", sum, v.s);
    chk("cout", cout, v.co);
`ifdef SERIAL_ADD_OVF_EN
    chk("ovf", ovf, v.ov);
`endif
    @(posedge clk);
    #1;
    if (busy) bc++;
    chk("done_one_cycle", done, 0);
    chk("busy_cycles", bc, 9);
    @(posedge clk);
    #1;
    chk("sum_held", sum, v.s);
    prev_sum = v.s;
  endtask

  initial begin
    int cnt;
    vec_t v;
    vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[8] = '{8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum, 8'h00);
    chk("reset_cout", cout, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (busy || done || sum != 8'h00 || cout) cnt++;
    end
    chk("idle_no_activity", cnt, 0);

    for (int i = 0; i < 9; i++) begin
      launch(vecs[i]);
      finish_op(vecs[i], 0);
    end

    // Start re-asserted mid-operation must not disturb the operation in flight.
    v = '{8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0, 1'b0};
    launch(v);
    finish_op(v, 3);
    cnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (busy || done) cnt++;
    end
    chk("ignored_start_no_rerun", cnt, 0);

    // Asynchronous reset mid-operation aborts with no done pulse.
    v = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
    launch(v);
    repeat (3) @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 8'h00);
    chk("abort_cout", cout, 0);
    cnt = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    prev_sum = 8'h00;
    launch(v);
    finish_op(v, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
